// File: rtl/booth_r4_seq_mult_pkg.sv
// Shared types and constant helpers for the radix-4 Booth sequential multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        PM   = 3'd1,
        P2M  = 3'd2,
        NM   = 3'd3,
        N2M  = 3'd4
    } digit_e;

    // Number of radix-4 digits needed for a width-bit operand (two extension bits included).
    function automatic int ndig(input int width);
        return width / 2 + 1;
    endfunction

    // Number of RUN cycles when d digits are retired per cycle.
    function automatic int ncyc(input int width, input int d);
        return (ndig(width) + d - 1) / d;
    endfunction

    // Map a multiplier bit triplet {q[2i+1], q[2i], q[2i-1]} to its Booth digit.
    function automatic digit_e booth_enc(input logic [2:0] trip);
        digit_e dig;
        case (trip)
            3'b000, 3'b111: dig = ZERO;
            3'b001, 3'b010: dig = PM;
            3'b011:         dig = P2M;
            3'b100:         dig = N2M;
            3'b101, 3'b110: dig = NM;
            default:        dig = ZERO;
        endcase
        return dig;
    endfunction

endpackage

// File: rtl/booth_r4_seq_mult_if.sv
// Operand / product handshake bundle of the Booth multiplier.
interface booth_r4_seq_mult_if #(
    parameter int WIDTH = 32
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sign;
    logic [WIDTH-1:0]     in_multiplicand;
    logic [WIDTH-1:0]     in_multiplier;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_product;

    modport master (
        output in_valid, in_sign, in_multiplicand, in_multiplier, out_ready,
        input  in_ready, out_valid, out_product
    );

    modport slave (
        input  in_valid, in_sign, in_multiplicand, in_multiplier, out_ready,
        output in_ready, out_valid, out_product
    );
endinterface

// File: rtl/booth_r4_seq_mult_pp_gen.sv
// One radix-4 Booth partial product: selects 0, +-M or +-2M from a multiplier triplet.
module booth_r4_pp_gen
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   m_ext_i,
    input  logic [2:0]       trip_i,
    output logic [WIDTH+1:0] pp_o
);
    logic [WIDTH+1:0] m1_s;
    logic [WIDTH+1:0] m2_s;

    // M and 2M widened to the partial-product width (M is already sign/zero extended).
    assign m1_s = {m_ext_i[WIDTH], m_ext_i};
    assign m2_s = {m_ext_i, 1'b0};

    // Pick the signed multiple of M encoded by the digit.
    always_comb begin
        pp_o = '0;
        case (booth_enc(trip_i))
            ZERO:    pp_o = '0;
            PM:      pp_o = m1_s;
            P2M:     pp_o = m2_s;
            NM:      pp_o = ~m1_s + {{(WIDTH + 1){1'b0}}, 1'b1};
            N2M:     pp_o = ~m2_s + {{(WIDTH + 1){1'b0}}, 1'b1};
            default: pp_o = '0;
        endcase
    end
endmodule

// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier retiring DIGITS_PER_CYCLE digits per RUN cycle.
module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int DIGITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    booth_r4_seq_mult_if.slave bus,
    output logic              busy
);
    localparam int D    = DIGITS_PER_CYCLE;
    localparam int NCYC = ncyc(WIDTH, D);
    // Shifted multiplier: appended 0, W bits, extension; padded so the last cycle has D triplets.
    localparam int QW   = 2 * NCYC * D + 1;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC + 1) : 1;
    localparam int PW   = 2 * WIDTH;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]  m_ext_q, m_ext_d;
    logic [QW-1:0]   q_sh_q, q_sh_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [PW-1:0]   sum_s;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;
    logic            accept_s;
    logic            last_s;

    logic [2:0]       trip_s [D];
    logic [WIDTH+1:0] pp_s   [D];
    logic [PW-1:0]    wpp_s  [D];

    assign accept_s = (state_q == IDLE) && bus.in_valid;
    assign last_s   = (state_q == RUN) && (cnt_q == CW'(NCYC - 1));

    // Digit j of this cycle is global digit cnt*D+j, weighted by 4^(cnt*D+j).
    // Padding above the extended multiplier repeats its top bit, so surplus digits decode to zero.
    for (genvar j = 0; j < D; j++) begin : g_dig
        assign trip_s[j] = q_sh_q[2*j+2 -: 3];
        booth_r4_pp_gen #(.WIDTH(WIDTH)) u_pp (
            .m_ext_i (m_ext_q),
            .trip_i  (trip_s[j]),
            .pp_o    (pp_s[j])
        );
        assign wpp_s[j] = {{(PW - WIDTH - 2){pp_s[j][WIDTH+1]}}, pp_s[j]}
                          << (32'(cnt_q) * 32'(2 * D) + 32'(2 * j));
    end

    // Accumulator plus this cycle's weighted partial products, modulo 2^(2W).
    always_comb begin
        sum_s = acc_q;
        for (int j = 0; j < D; j++) begin
            sum_s = sum_s + wpp_s[j];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after NCYC cycles, DONE -> IDLE on handoff.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) state_d = RUN;
                else          state_d = IDLE;
            end
            RUN: begin
                if (last_s) state_d = DONE;
                else        state_d = RUN;
            end
            DONE: begin
                if (out_valid_q && bus.out_ready) state_d = IDLE;
                else                              state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs follow the state being entered so they can be registered.
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // Datapath next state: capture operands on accept, accumulate and shift while running.
    always_comb begin
        m_ext_d = m_ext_q;
        q_sh_d  = q_sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    m_ext_d = {bus.in_sign & bus.in_multiplicand[WIDTH-1], bus.in_multiplicand};
                    q_sh_d  = {{(QW - WIDTH - 1){bus.in_sign & bus.in_multiplier[WIDTH-1]}},
                               bus.in_multiplier, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    acc_d   = acc_q;
                end
            end
            RUN: begin
                acc_d  = sum_s;
                cnt_d  = cnt_q + CW'(1);
                q_sh_d = $signed(q_sh_q) >>> (2 * D);
                if (last_s) prod_d = sum_s;
                else        prod_d = prod_q;
            end
            DONE:    prod_d = prod_q;
            default: prod_d = prod_q;
        endcase
    end

    // Datapath and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ext_q     <= '0;
            q_sh_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            prod_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            m_ext_q     <= m_ext_d;
            q_sh_q      <= q_sh_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_product = prod_q;
    assign busy            = busy_q;
endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Scoreboard bench: 32-bit D=1 multiplier with directed cases, plus 8-bit D=1/2/5 random sweeps.
module tb_booth_r4_seq_mult;
    logic clk = 1'b0;
    logic rst_n;
    logic rst_b_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;
    int n_done8 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Exact product of two w-bit operands, reduced modulo 2^(2w).
    function automatic logic [63:0] ref_mul(input int w, input logic sgn,
                                            input logic [31:0] m, input logic [31:0] q);
        longint mv, qv, p;
        logic [63:0] r;
        mv = longint'({32'd0, m});
        qv = longint'({32'd0, q});
        if (sgn && m[w-1]) mv = mv - (longint'(1) << w);
        if (sgn && q[w-1]) qv = qv - (longint'(1) << w);
        p = mv * qv;
        r = p;
        if (w < 32) r = r & ((64'd1 << (2 * w)) - 64'd1);
        return r;
    endfunction

    // ---------------- 32-bit, one digit per cycle ----------------
    booth_r4_seq_mult_if #(.WIDTH(32)) ifa ();
    logic busy_a;
    booth_r4_seq_mult #(.WIDTH(32), .DIGITS_PER_CYCLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa), .busy(busy_a)
    );

    logic [63:0] exp_a[$];
    int          acc_a[$];
    logic        pv_a = 1'b0;
    bit          rand_bp_a = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ifa.out_valid && !pv_a) begin
                if (acc_a.size() == 0) chk("a_spurious_valid", 64'd1, 64'd0);
                else chk("a_latency", 64'(cyc - acc_a.pop_front()), 64'd17);
            end
            if (ifa.out_valid && ifa.out_ready) begin
                if (exp_a.size() == 0) chk("a_spurious_product", 64'd1, 64'd0);
                else chk("a_product", ifa.out_product, exp_a.pop_front());
            end
        end
        pv_a = ifa.out_valid;
    end

    always @(posedge clk) begin
        if (rand_bp_a) begin
            #1;
            ifa.out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic issue_a(input logic sgn, input logic [31:0] m, input logic [31:0] q);
        int b = 0;
        @(negedge clk);
        ifa.in_valid = 1'b1;
        ifa.in_sign = sgn;
        ifa.in_multiplicand = m;
        ifa.in_multiplier = q;
        while (!ifa.in_ready && b < 100) begin
            @(negedge clk);
            b++;
        end
        if (!ifa.in_ready) begin
            chk("a_accept_timeout", 64'd0, 64'd1);
            ifa.in_valid = 1'b0;
        end else begin
            exp_a.push_back(ref_mul(32, sgn, m, q));
            acc_a.push_back(cyc + 1);
            @(posedge clk);
            #1;
            ifa.in_valid = 1'b0;
            ifa.in_multiplicand = $urandom;
            ifa.in_multiplier = $urandom;
            ifa.in_sign = ~sgn;
        end
    endtask

    task automatic drain_a();
        int b = 0;
        while (exp_a.size() != 0 && b < 400) begin
            @(negedge clk);
            b++;
        end
        if (exp_a.size() != 0) begin
            chk("a_drain_timeout", 64'(exp_a.size()), 64'd0);
            exp_a.delete();
            acc_a.delete();
        end
    endtask

    // ---------------- 8-bit sweeps with D = 1, 2, 5 ----------------
    for (genvar g = 0; g < 3; g++) begin : g_w8
        localparam int D8  = (g == 0) ? 1 : ((g == 1) ? 2 : 5);
        localparam int NC8 = (5 + D8 - 1) / D8;

        booth_r4_seq_mult_if #(.WIDTH(8)) bif ();
        logic busy_b;
        booth_r4_seq_mult #(.WIDTH(8), .DIGITS_PER_CYCLE(D8)) dut_b (
            .clk(clk), .rst_n(rst_b_n), .bus(bif), .busy(busy_b)
        );

        logic [63:0] exp_q[$];
        int          acc_q[$];
        logic        pv = 1'b0;

        initial begin : drv
            logic sgn;
            logic [7:0] m, q;
            int b;
            bif.in_valid = 1'b0;
            bif.in_sign = 1'b0;
            bif.in_multiplicand = 8'd0;
            bif.in_multiplier = 8'd0;
            bif.out_ready = 1'b1;
            wait (rst_b_n === 1'b1);
            for (int n = 0; n < 400; n++) begin
                sgn = 1'($urandom_range(0, 1));
                m = 8'($urandom);
                q = 8'($urandom);
                case (n)
                    0: begin sgn = 1'b1; m = 8'h80; q = 8'h80; end
                    1: begin sgn = 1'b1; m = 8'hFF; q = 8'hFF; end
                    2: begin sgn = 1'b0; m = 8'hFF; q = 8'hFF; end
                    3: begin sgn = 1'b1; m = 8'h80; q = 8'h7F; end
                    4: begin sgn = 1'b0; m = 8'h00; q = 8'h00; end
                    5: begin sgn = 1'b0; m = 8'h80; q = 8'h80; end
                    default: ;
                endcase
                @(negedge clk);
                bif.in_valid = 1'b1;
                bif.in_sign = sgn;
                bif.in_multiplicand = m;
                bif.in_multiplier = q;
                b = 0;
                while (!bif.in_ready && b < 100) begin
                    @(negedge clk);
                    b++;
                end
                if (!bif.in_ready) begin
                    chk($sformatf("w8_d%0d_accept_timeout", D8), 64'd0, 64'd1);
                    bif.in_valid = 1'b0;
                end else begin
                    exp_q.push_back(ref_mul(8, sgn, 32'(m), 32'(q)));
                    acc_q.push_back(cyc + 1);
                    @(posedge clk);
                    #1;
                    bif.in_valid = 1'b0;
                    bif.in_multiplicand = 8'($urandom);
                    bif.in_multiplier = 8'($urandom);
                    bif.in_sign = ~sgn;
                end
                if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
            b = 0;
            while (exp_q.size() != 0 && b < 400) begin
                @(negedge clk);
                b++;
            end
            if (exp_q.size() != 0) chk($sformatf("w8_d%0d_drain_timeout", D8), 64'(exp_q.size()), 64'd0);
            n_done8++;
        end

        always @(posedge clk) begin
            #1;
            bif.out_ready = ($urandom_range(0, 3) != 0);
        end

        always @(negedge clk) begin
            if (rst_b_n) begin
                if (bif.out_valid && !pv) begin
                    chk($sformatf("w8_d%0d_busy", D8), 64'(busy_b), 64'd1);
                    if (acc_q.size() == 0) chk($sformatf("w8_d%0d_spurious_valid", D8), 64'd1, 64'd0);
                    else chk($sformatf("w8_d%0d_latency", D8), 64'(cyc - acc_q.pop_front()), 64'(NC8));
                end
                if (bif.out_valid && bif.out_ready) begin
                    if (exp_q.size() == 0) chk($sformatf("w8_d%0d_spurious_product", D8), 64'd1, 64'd0);
                    else chk($sformatf("w8_d%0d_product", D8), 64'(bif.out_product), exp_q.pop_front());
                end
            end
            pv = bif.out_valid;
        end
    end

    // ---------------- main sequence for the 32-bit instance ----------------
    initial begin : main
        logic [63:0] expp;
        int b;
        int spurious;
        rst_n = 1'b0;
        rst_b_n = 1'b0;
        ifa.in_valid = 1'b0;
        ifa.in_sign = 1'b0;
        ifa.in_multiplicand = 32'd0;
        ifa.in_multiplier = 32'd0;
        ifa.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(ifa.in_ready), 64'd1);
        chk("rst_out_valid", 64'(ifa.out_valid), 64'd0);
        chk("rst_out_product", ifa.out_product, 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        rst_n = 1'b1;
        rst_b_n = 1'b1;

        // Directed products
        issue_a(1'b1, 32'hFFFF_FFFD, 32'd7);
        issue_a(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue_a(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue_a(1'b1, 32'h8000_0000, 32'h8000_0000);
        issue_a(1'b1, 32'h8000_0000, 32'd1);
        issue_a(1'b0, 32'd0, 32'd0);
        drain_a();

        // Back-pressure with a competing request held during DONE
        ifa.out_ready = 1'b0;
        issue_a(1'b1, 32'd12345, 32'hFFFF_FD5A);
        b = 0;
        while (!ifa.out_valid && b < 40) begin
            @(negedge clk);
            b++;
        end
        chk("bp_valid_seen", 64'(ifa.out_valid), 64'd1);
        expp = ref_mul(32, 1'b1, 32'd12345, 32'hFFFF_FD5A);
        ifa.in_valid = 1'b1;
        ifa.in_sign = 1'b0;
        ifa.in_multiplicand = 32'hDEAD_BEEF;
        ifa.in_multiplier = 32'h0000_1234;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(ifa.out_valid), 64'd1);
            chk("bp_hold_product", ifa.out_product, expp);
            chk("bp_in_ready_low", 64'(ifa.in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        ifa.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_valid", 64'(ifa.out_valid), 64'd0);
        chk("bp_release_idle", 64'(ifa.in_ready), 64'd1);
        exp_a.push_back(ref_mul(32, 1'b0, 32'hDEAD_BEEF, 32'h0000_1234));
        acc_a.push_back(cyc + 1);
        @(posedge clk);
        #1;
        ifa.in_valid = 1'b0;
        drain_a();

        // Asynchronous reset in the middle of RUN
        issue_a(1'b1, 32'h1357_9BDF, 32'hFEDC_BA98);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_async_in_ready", 64'(ifa.in_ready), 64'd1);
        chk("rst_async_out_valid", 64'(ifa.out_valid), 64'd0);
        chk("rst_async_out_product", ifa.out_product, 64'd0);
        chk("rst_async_busy", 64'(busy_a), 64'd0);
        exp_a.delete();
        acc_a.delete();
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        repeat (30) begin
            @(negedge clk);
            if (ifa.out_valid) spurious++;
        end
        chk("rst_no_valid_after", 64'(spurious), 64'd0);
        issue_a(1'b1, 32'h7FFF_FFFF, 32'h8000_0001);
        drain_a();

        // Random operands with random back-pressure
        rand_bp_a = 1'b1;
        for (int k = 0; k < 40; k++) begin
            logic [31:0] m, q;
            m = $urandom;
            q = $urandom;
            if (k % 5 == 0) m = 32'h8000_0000;
            if (k % 7 == 0) q = 32'hFFFF_FFFF;
            issue_a(1'($urandom_range(0, 1)), m, q);
        end
        drain_a();
        rand_bp_a = 1'b0;
        @(posedge clk);
        #2;
        ifa.out_ready = 1'b1;

        b = 0;
        while (n_done8 < 3 && b < 30000) begin
            @(negedge clk);
            b++;
        end
        if (n_done8 < 3) chk("w8_timeout", 64'(n_done8), 64'd3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
